// File: rtl/sd_spi_target_pkg.sv
// Shared types and defaults for the SD-card SPI mode-0 target.
package sd_spi_target_pkg;

  localparam int         DEF_DATA_W    = 8;
  localparam logic [7:0] DEF_FILL_BYTE = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/sd_spi_target_if.sv
// SPI pins plus the RX/TX byte streams of the SD-card SPI target.
interface sd_spi_target_if #(
  parameter int DATA_W = 8
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              overrun;
  logic              selected;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, rx_ready, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, overrun, selected
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, rx_ready, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, overrun, selected
  );
endinterface

// File: rtl/sd_spi_target_sync.sv
// N-stage synchroniser for one asynchronous SPI pin, reset to a chosen level.
module plasma_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= {STAGES{RST_VAL}};
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sd_spi_target.sv
// SPI mode-0 target: oversampled pins, MOSI bytes to an RX stream, TX stream onto MISO.
//
// state     | meaning
// ST_IDLE   | deselected, miso parked high, sclk ignored
// ST_ACTIVE | cs_n low, bytes framed on sclk edges
module sd_spi_target
  import sd_spi_target_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_BYTE   = DATA_W'(DEF_FILL_BYTE)
) (
  input  logic            clk,
  input  logic            reset,
  sd_spi_target_if.slave  bus
);

  localparam int              CNT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);
  localparam logic [0:0]      IDLE   = ST_IDLE;
  localparam logic [0:0]      ACTIVE = ST_ACTIVE;

  logic sclk_s, cs_n_s, mosi_s;

  // cs_n syncs to 0 so a select held low through reset never looks like a fall
  plasma_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(bus.spi_sclk), .q_o(sclk_s));
  plasma_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset(reset), .d_i(bus.spi_cs_n), .q_o(cs_n_s));
  plasma_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(bus.spi_mosi), .q_o(mosi_s));

  logic sclk_dly_q, cs_dly_q;
  logic sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q, mosi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_n_s;
      sclk_rise_q <= sclk_s & ~sclk_dly_q;
      sclk_fall_q <= ~sclk_s & sclk_dly_q;
      cs_rise_q   <= cs_n_s & ~cs_dly_q;
      cs_fall_q   <= ~cs_n_s & cs_dly_q;
      mosi_q      <= mosi_s;
    end
  end

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              held_q, held_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;

  logic              load, frame_done, tx_accept, rx_take;
  logic [DATA_W-1:0] load_byte, rx_byte;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    hold_d     = hold_q;
    held_d     = held_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    load       = 1'b0;
    frame_done = 1'b0;
    tx_accept  = bus.tx_valid && !held_q;
    rx_take    = rx_valid_q && bus.rx_ready;
    load_byte  = held_q ? hold_q : FILL_BYTE;
    rx_byte    = {rx_shift_q, mosi_q};

    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (cs_fall_q) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          load      = 1'b1;
          miso_d    = load_byte[DATA_W-1];
        end
      end
      default: begin
        if (cs_rise_q) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b1;
        end else if (sclk_rise_q) begin
          rx_shift_d = rx_byte[DATA_W-2:0];
          if (bit_cnt_q == LAST) begin
            bit_cnt_d  = '0;
            frame_done = 1'b1;
            load       = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall_q) begin
          // count at zero means the shifter was just reloaded: present its MSB unshifted
          if (bit_cnt_q == '0) begin
            miso_d = tx_shift_q[DATA_W-1];
          end else begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end
        end
      end
    endcase

    if (load) begin
      tx_shift_d = load_byte;
      held_d     = 1'b0;
    end
    if (tx_accept) begin
      hold_d = bus.tx_data;
      held_d = 1'b1;
    end

    if (rx_take) rx_valid_d = 1'b0;
    if (frame_done) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      miso_q     <= 1'b1;
      hold_q     <= '0;
      held_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      miso_q     <= miso_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.selected    = (state_q == ACTIVE);
  assign bus.spi_miso_oe = (state_q == ACTIVE);
  assign bus.tx_ready    = !held_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.overrun     = overrun_q;

endmodule
